// File: rtl/spi_fb_writer.sv
// SPI slave (mode 0) that streams command/address/data bytes into one or two framebuffer panels.
// Optional frame-done strobe on address wrap: define SPI_FB_FRAME_STROBE_EN.
module spi_fb_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_sclk,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_mosi,
  output logic [ADDR_W-1:0] o_waddr_1,
  output logic [ADDR_W-1:0] o_waddr_2,
  output logic [DATA_W-1:0] o_wdata_1,
  output logic [DATA_W-1:0] o_wdata_2,
  output logic              o_we_1,
  output logic              o_we_2,
  output logic              o_frame_done
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  logic [1:0]        sclk_sync, cs_sync, mosi_sync, vld_sync;
  logic              sclk_prev, cs_prev, armed;
  logic              sclk_rise, cs_fall, cs_rise;

  logic [2:0]        state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        byte_val;
  logic [DATA_W-1:0] word_val;
  logic              byte_done;
  logic              wr;

  // Synchronizers; armed only once a real (post-reset) high cs_n has been seen
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      vld_sync  <= 2'b00;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], i_spi_sclk};
      cs_sync   <= {cs_sync[0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[0], i_spi_mosi};
      vld_sync  <= {vld_sync[0], 1'b1};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
      armed     <= armed | (vld_sync[1] & cs_sync[1]);
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign cs_fall   = armed & cs_prev & ~cs_sync[1];
  assign cs_rise   = cs_sync[1] & ~cs_prev;

  assign byte_val  = {shift_q[6:0], mosi_sync[1]};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign word_val  = DATA_W'({word_q, byte_val});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
    end
  end

  // Next-state and datapath; a word-completing edge still writes when cs_n rises with it
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wr         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d    = S_CMD;
          shift_d    = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          word_d     = '0;
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (sclk_rise) begin
          shift_d   = byte_val;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
          if (state_q == S_CMD) begin
            if (byte_val == 8'h01 || byte_val == 8'h02 || byte_val == 8'h03) begin
              sel_d   = byte_val[1:0];
              state_d = S_ADDR;
            end else begin
              state_d = S_DISCARD;
            end
          end else if (state_q == S_ADDR) begin
            addr_d  = ADDR_W'(byte_val);
            state_d = S_DATA;
          end else begin
            word_d = word_val;
            if (byte_cnt_q == BCNT_W'(BYTES - 1)) begin
              wr         = 1'b1;
              byte_cnt_d = '0;
              addr_d     = addr_q + ADDR_W'(1);
            end else begin
              byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            end
          end
        end
      end
      S_DISCARD: ;
      default: state_d = S_IDLE;
    endcase

    if (cs_rise) state_d = S_IDLE;
  end

  // Registered write ports; address/data hold between strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_we_1    <= 1'b0;
      o_we_2    <= 1'b0;
      o_waddr_1 <= '0;
      o_waddr_2 <= '0;
      o_wdata_1 <= '0;
      o_wdata_2 <= '0;
    end else begin
      o_we_1 <= wr & sel_q[0];
      o_we_2 <= wr & sel_q[1];
      if (wr & sel_q[0]) begin
        o_waddr_1 <= addr_q;
        o_wdata_1 <= word_val;
      end
      if (wr & sel_q[1]) begin
        o_waddr_2 <= addr_q;
        o_wdata_2 <= word_val;
      end
    end
  end

`ifdef SPI_FB_FRAME_STROBE_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_frame_done <= 1'b0;
    else          o_frame_done <= wr && (addr_q == {ADDR_W{1'b1}});
  end
`else
  assign o_frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fb_writer.sv
// Directed self-checking bench for spi_fb_writer.
module tb_spi_fb_writer;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

`ifdef SPI_FB_FRAME_STROBE_EN
  localparam int FD_ON = 1;
`else
  localparam int FD_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic [ADDR_W-1:0] waddr_1, waddr_2;
  logic [DATA_W-1:0] wdata_1, wdata_2;
  logic we_1, we_2, frame_done;

  int n_tests = 0;
  int n_fail = 0;

  logic [23:0] w1_q[$];
  logic [23:0] w2_q[$];
  int fd_cnt = 0;
  int fd_bad = 0;

  spi_fb_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi),
    .o_waddr_1(waddr_1), .o_waddr_2(waddr_2),
    .o_wdata_1(wdata_1), .o_wdata_2(wdata_2),
    .o_we_1(we_1), .o_we_2(we_2), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Record every strobe cycle; a multi-cycle strobe shows up as an extra entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_1) w1_q.push_back({waddr_1, wdata_1});
      if (we_2) w2_q.push_back({waddr_2, wdata_2});
      if (frame_done) begin
        fd_cnt++;
        if (!(we_1 || we_2) || (we_1 && waddr_1 != 8'hFF) || (we_2 && waddr_2 != 8'hFF)) fd_bad++;
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_end();
    #40 cs_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({we_1, we_2, frame_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000", {we_1, we_2, frame_done});
    end
    n_tests++;
    if ({waddr_1, waddr_2, wdata_1, wdata_2} !== '0) begin
      n_fail++; $display("FAIL reset_buses got %h %h %h %h want 0", waddr_1, waddr_2, wdata_1, wdata_2);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_write();
    int b1 = w1_q.size();
    int b2 = w2_q.size();
    cs_start();
    spi_byte(8'h01); spi_byte(8'h10); spi_byte(8'hAB); spi_byte(8'hCD);
    cs_end();
    n_tests++;
    if (w1_q.size() - b1 !== 1) begin
      n_fail++; $display("FAIL single_count got %0d want 1", w1_q.size() - b1);
    end else begin
      n_tests++;
      if (w1_q[b1] !== 24'h10ABCD) begin
        n_fail++; $display("FAIL single_word got %h want 10abcd", w1_q[b1]);
      end
    end
    n_tests++;
    if (w2_q.size() - b2 !== 0) begin
      n_fail++; $display("FAIL single_p2_idle got %0d want 0", w2_q.size() - b2);
    end
    n_tests++;
    if ({we_1, waddr_1, wdata_1} !== {1'b0, 8'h10, 16'hABCD}) begin
      n_fail++; $display("FAIL single_hold got %b %h %h want 0 10 abcd", we_1, waddr_1, wdata_1);
    end
  endtask

  task automatic test_wrap_both();
    int b1 = w1_q.size();
    int b2 = w2_q.size();
    int f0 = fd_cnt;
    cs_start();
    spi_byte(8'h03); spi_byte(8'hFF);
    spi_byte(8'h12); spi_byte(8'h34); spi_byte(8'h56); spi_byte(8'h78);
    cs_end();
    n_tests++;
    if (w1_q.size() - b1 !== 2 || w2_q.size() - b2 !== 2) begin
      n_fail++; $display("FAIL wrap_count got %0d/%0d want 2/2", w1_q.size() - b1, w2_q.size() - b2);
    end else begin
      n_tests++;
      if (w1_q[b1] !== 24'hFF1234 || w1_q[b1+1] !== 24'h005678) begin
        n_fail++; $display("FAIL wrap_p1 got %h %h want ff1234 005678", w1_q[b1], w1_q[b1+1]);
      end
      n_tests++;
      if (w2_q[b2] !== 24'hFF1234 || w2_q[b2+1] !== 24'h005678) begin
        n_fail++; $display("FAIL wrap_p2 got %h %h want ff1234 005678", w2_q[b2], w2_q[b2+1]);
      end
    end
    n_tests++;
    if (fd_cnt - f0 !== FD_ON || fd_bad !== 0) begin
      n_fail++; $display("FAIL wrap_frame_done got %0d (bad %0d) want %0d", fd_cnt - f0, fd_bad, FD_ON);
    end
  endtask

  task automatic test_discard();
    int b1 = w1_q.size();
    int b2 = w2_q.size();
    cs_start();
    spi_byte(8'h7E);
    for (int i = 0; i < 20; i++) spi_byte(8'(i * 13 + 1));
    cs_end();
    n_tests++;
    if (w1_q.size() - b1 !== 0 || w2_q.size() - b2 !== 0) begin
      n_fail++; $display("FAIL discard_writes got %0d/%0d want 0/0", w1_q.size() - b1, w2_q.size() - b2);
    end
    cs_start();
    spi_byte(8'h02); spi_byte(8'h05); spi_byte(8'hBE); spi_byte(8'hEF);
    cs_end();
    n_tests++;
    if (w2_q.size() - b2 !== 1 || w1_q.size() - b1 !== 0) begin
      n_fail++; $display("FAIL after_discard_count got %0d/%0d want 0/1", w1_q.size() - b1, w2_q.size() - b2);
    end else begin
      n_tests++;
      if (w2_q[b2] !== 24'h05BEEF) begin
        n_fail++; $display("FAIL after_discard_word got %h want 05beef", w2_q[b2]);
      end
    end
  endtask

  task automatic test_partial();
    int b1 = w1_q.size();
    cs_start();
    spi_byte(8'h01); spi_byte(8'h00);
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33);
    cs_end();
    n_tests++;
    if (w1_q.size() - b1 !== 1) begin
      n_fail++; $display("FAIL partial_word_count got %0d want 1", w1_q.size() - b1);
    end else begin
      n_tests++;
      if (w1_q[b1] !== 24'h001122) begin
        n_fail++; $display("FAIL partial_word got %h want 001122", w1_q[b1]);
      end
    end
    b1 = w1_q.size();
    cs_start();
    spi_byte(8'h01); spi_byte(8'h20); spi_byte(8'hAA); spi_bits(8'hF0, 4);
    cs_end();
    n_tests++;
    if (w1_q.size() - b1 !== 0) begin
      n_fail++; $display("FAIL partial_byte_count got %0d want 0", w1_q.size() - b1);
    end
  endtask

  task automatic test_back_to_back();
    int b1 = w1_q.size();
    int f0 = fd_cnt;
    cs_start();
    spi_byte(8'h01); spi_byte(8'hFE);
    spi_byte(8'h00); spi_byte(8'h01);
    spi_byte(8'h00); spi_byte(8'h02);
    spi_byte(8'h00); spi_byte(8'h03);
    cs_end();
    n_tests++;
    if (w1_q.size() - b1 !== 3) begin
      n_fail++; $display("FAIL b2b_count got %0d want 3", w1_q.size() - b1);
    end else begin
      n_tests++;
      if (w1_q[b1] !== 24'hFE0001 || w1_q[b1+1] !== 24'hFF0002 || w1_q[b1+2] !== 24'h000003) begin
        n_fail++; $display("FAIL b2b_words got %h %h %h want fe0001 ff0002 000003",
                           w1_q[b1], w1_q[b1+1], w1_q[b1+2]);
      end
    end
    n_tests++;
    if (fd_cnt - f0 !== FD_ON) begin
      n_fail++; $display("FAIL b2b_frame_done got %0d want %0d", fd_cnt - f0, FD_ON);
    end
  endtask

  task automatic test_reset_mid();
    int b1 = w1_q.size();
    int b2 = w2_q.size();
    cs_start();
    spi_byte(8'h01); spi_byte(8'h40); spi_byte(8'h55); spi_bits(8'hA0, 4);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_tests++;
    if ({we_1, we_2, frame_done, waddr_1, waddr_2, wdata_1, wdata_2} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got %b%b%b %h %h %h %h want all 0",
                         we_1, we_2, frame_done, waddr_1, waddr_2, wdata_1, wdata_2);
    end
    @(negedge clk) rst_n = 1'b1;
    spi_bits(8'h0A, 4);
    spi_byte(8'h66); spi_byte(8'h77); spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h99); spi_byte(8'h88);
    n_tests++;
    if (w1_q.size() - b1 !== 0 || w2_q.size() - b2 !== 0) begin
      n_fail++; $display("FAIL midreset_no_write got %0d/%0d want 0/0", w1_q.size() - b1, w2_q.size() - b2);
    end
    cs_end();
    cs_start();
    spi_byte(8'h01); spi_byte(8'h41); spi_byte(8'h12); spi_byte(8'h34);
    cs_end();
    n_tests++;
    if (w1_q.size() - b1 !== 1) begin
      n_fail++; $display("FAIL midreset_resume_count got %0d want 1", w1_q.size() - b1);
    end else begin
      n_tests++;
      if (w1_q[b1] !== 24'h411234) begin
        n_fail++; $display("FAIL midreset_resume_word got %h want 411234", w1_q[b1]);
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_single_write();
    test_wrap_both();
    test_discard();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
